// File: rtl/lstm_pkg.sv
// Shared defaults, vector typedef and FSM encoding for the LSTM step sequencer.
// Latency: none (definitions only).
// Backpressure: n/a.
package lstm_pkg;

  localparam int LSTM_VEC_LEN = 100;
  localparam int LSTM_DATA_W  = 32;

  typedef logic signed [LSTM_DATA_W-1:0] elem_t;
  typedef elem_t [LSTM_VEC_LEN-1:0]      vec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Step counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lstm_state_bank.sv
// Recurrent h/c storage: clear on sequence start, load on step completion, else hold.
// Latency: one cycle from clear/load to h_q/c_q.
// Backpressure: none; caller decides when to clear or load.
module lstm_state_bank
  import lstm_pkg::*;
#(
  parameter int WIDTH = LSTM_VEC_LEN * LSTM_DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] h_in,
  input  logic [WIDTH-1:0] c_in,
  output logic [WIDTH-1:0] h_q,
  output logic [WIDTH-1:0] c_q
);

  // Clear has priority over load; the two are never asserted together by the sequencer.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      h_q <= '0;
      c_q <= '0;
    end else if (load) begin
      h_q <= h_in;
      c_q <= c_in;
    end
  end

endmodule

// File: rtl/lstm_step_seq.sv
// Sequences one LSTM timestep per accepted input through an external combinational cell.
// Latency: out_valid rises SETTLE_CYC+1 cycles after the accept edge.
// Backpressure: in_ready only in IDLE; out_h/out_last hold in OUT until out_ready.
module lstm_step_seq
  import lstm_pkg::*;
#(
  parameter int VEC_LEN    = LSTM_VEC_LEN,
  parameter int DATA_W     = LSTM_DATA_W,
  parameter int SETTLE_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic [VEC_LEN*DATA_W-1:0] x_in,
  output logic [VEC_LEN*DATA_W-1:0] cell_x,
  output logic [VEC_LEN*DATA_W-1:0] cell_h_prev,
  output logic [VEC_LEN*DATA_W-1:0] cell_c_prev,
  input  logic [VEC_LEN*DATA_W-1:0] cell_h_t,
  input  logic [VEC_LEN*DATA_W-1:0] cell_c_next,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [VEC_LEN*DATA_W-1:0] out_h,
  output logic                      out_last,
  output logic [15:0]               step_cnt
);

  localparam int VW = VEC_LEN * DATA_W;
  // Counter value on the last settle cycle; counter is 4 bits since SETTLE_CYC <= 15.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t          state_q;
  state_t          state_d;
  logic [3:0]      settle_cnt;
  logic [VW-1:0]   x_reg;
  logic            last_reg;
  logic            accept;
  logic            eval_done;

  // Cell operands come straight from the registers so they cannot move during EVAL.
  assign cell_x = x_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    eval_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (settle_cnt == SETTLE_LAST) begin
          eval_done = 1'b1;
          state_d   = ST_OUT;
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Input capture, settle timing and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg      <= '0;
      last_reg   <= 1'b0;
      settle_cnt <= '0;
      out_h      <= '0;
      out_last   <= 1'b0;
    end else begin
      if (accept) begin
        x_reg      <= x_in;
        last_reg   <= in_last;
        settle_cnt <= '0;
      end else if (state_q == ST_EVAL) begin
        settle_cnt <= settle_cnt + 4'd1;
      end
      if (eval_done) begin
        out_h    <= cell_h_t;
        out_last <= last_reg;
      end
    end
  end

  // Steps completed in the current sequence; restarts on a first-step accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (accept && in_first) begin
      step_cnt <= '0;
    end else if (eval_done) begin
      step_cnt <= sat_inc16(step_cnt);
    end
  end

  lstm_state_bank #(
    .WIDTH (VW)
  ) u_state_bank (
    .clk   (clk),
    .rst   (rst),
    .clear (accept && in_first),
    .load  (eval_done),
    .h_in  (cell_h_t),
    .c_in  (cell_c_next),
    .h_q   (cell_h_prev),
    .c_q   (cell_c_prev)
  );

endmodule

// File: tb/tb_lstm_step_seq.sv
// Directed bench for lstm_step_seq with an additive stand-in for the LSTM cell.
// Latency: checks exact out_valid timing for SETTLE_CYC = 2.
// Backpressure: exercises held out_ready and mid-step reset.
module tb_lstm_step_seq;

  localparam int VL = 100;
  localparam int DW = 32;
  localparam int SC = 2;
  localparam int VW = VL * DW;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_first;
  logic          in_last;
  logic [VW-1:0] x_in;
  logic [VW-1:0] cell_x;
  logic [VW-1:0] cell_h_prev;
  logic [VW-1:0] cell_c_prev;
  logic [VW-1:0] cell_h_t;
  logic [VW-1:0] cell_c_next;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_h;
  logic          out_last;
  logic [15:0]   step_cnt;

  int checks;
  int failures;

  lstm_step_seq #(
    .VEC_LEN    (VL),
    .DATA_W     (DW),
    .SETTLE_CYC (SC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_first    (in_first),
    .in_last     (in_last),
    .x_in        (x_in),
    .cell_x      (cell_x),
    .cell_h_prev (cell_h_prev),
    .cell_c_prev (cell_c_prev),
    .cell_h_t    (cell_h_t),
    .cell_c_next (cell_c_next),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_h       (out_h),
    .out_last    (out_last),
    .step_cnt    (step_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in cell: h_t = x + h_prev, c_next = c_prev + 1, per element.
  always_comb begin
    cell_h_t    = '0;
    cell_c_next = '0;
    for (int i = 0; i < VL; i++) begin
      cell_h_t[i*DW +: DW]    = cell_x[i*DW +: DW] + cell_h_prev[i*DW +: DW];
      cell_c_next[i*DW +: DW] = cell_c_prev[i*DW +: DW] + 32'd1;
    end
  end

  function automatic logic [VW-1:0] fill(input int v);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < VL; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    int idx;
    idx = 0;
    for (int i = VL - 1; i >= 0; i--)
      if (obs[i*DW +: DW] !== exp[i*DW +: DW]) idx = i;
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s elem[%0d] observed=%0d expected=%0d", tag, idx,
             $signed(obs[idx*DW +: DW]), $signed(exp[idx*DW +: DW]));
    end
  endtask

  // Waits for in_ready, offers one step, then waits for out_valid and samples outputs.
  // The caller's next tick completes the output handshake when out_ready is high.
  task automatic run_step(input int xv, input bit first, input bit last,
                          output logic [VW-1:0] h, output logic lst, output logic [15:0] sc);
    bit got;
    for (int n = 0; n < 50 && !in_ready; n++) tick();
    in_valid = 1'b1;
    x_in     = fill(xv);
    in_first = first;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (out_valid) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("out_valid_timeout", 32'(got), 32'd1);
    h   = out_h;
    lst = out_last;
    sc  = step_cnt;
  endtask

  logic [VW-1:0] h;
  logic          lst;
  logic [15:0]   sc;

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    x_in      = '0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_step_cnt", 32'(step_cnt), 32'd0);
    chk_vec("rst_out_h", out_h, fill(0));
    chk_vec("rst_h_prev", cell_h_prev, fill(0));
    chk_vec("rst_c_prev", cell_c_prev, fill(0));
    chk_vec("rst_cell_x", cell_x, fill(0));

    // First step with exact timing: accept edge is cycle 0
    in_valid = 1'b1;
    x_in     = fill(5);
    in_first = 1'b1;
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    chk("c1_in_ready", 32'(in_ready), 32'd0);
    chk("c1_out_valid", 32'(out_valid), 32'd0);
    chk_vec("c1_cell_x", cell_x, fill(5));
    tick();
    chk("c2_in_ready", 32'(in_ready), 32'd0);
    chk("c2_out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("c3_in_ready", 32'(in_ready), 32'd0);
    chk("c3_out_valid", 32'(out_valid), 32'd1);
    chk_vec("s1_out_h_1", out_h, fill(5));
    chk("s1_step_cnt_1", 32'(step_cnt), 32'd1);
    chk("s1_out_last_1", 32'(out_last), 32'd0);
    tick();
    chk("s1_idle_in_ready", 32'(in_ready), 32'd1);

    run_step(5, 1'b0, 1'b0, h, lst, sc);
    tick();
    chk_vec("s1_out_h_2", h, fill(10));
    chk("s1_step_cnt_2", 32'(sc), 32'd2);
    run_step(5, 1'b0, 1'b1, h, lst, sc);
    tick();
    chk_vec("s1_out_h_3", h, fill(15));
    chk("s1_out_last_3", 32'(lst), 32'd1);
    chk("s1_step_cnt_3", 32'(sc), 32'd3);
    chk_vec("s1_c_reg", cell_c_prev, fill(3));
    chk_vec("s1_h_reg", cell_h_prev, fill(15));

    // Held output; also continues from state after an in_last step
    out_ready = 1'b0;
    run_step(1, 1'b0, 1'b0, h, lst, sc);
    chk_vec("s3_out_h", h, fill(16));
    for (int k = 0; k < 10; k++) begin
      chk_vec("s3_hold_out_h", out_h, fill(16));
      chk("s3_hold_in_ready", 32'(in_ready), 32'd0);
      chk("s3_hold_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("s3_rel_in_ready", 32'(in_ready), 32'd1);
    chk("s3_rel_out_valid", 32'(out_valid), 32'd0);
    chk("s3_rel_step_cnt", 32'(step_cnt), 32'd4);

    // New sequence after two steps
    run_step(2, 1'b1, 1'b0, h, lst, sc);
    tick();
    chk_vec("s4_pre_1", h, fill(2));
    run_step(2, 1'b0, 1'b0, h, lst, sc);
    tick();
    chk_vec("s4_pre_2", h, fill(4));
    chk("s4_pre_cnt", 32'(sc), 32'd2);
    run_step(7, 1'b1, 1'b0, h, lst, sc);
    tick();
    chk_vec("s4_out_h", h, fill(7));
    chk("s4_step_cnt", 32'(sc), 32'd1);
    chk_vec("s4_c_reg", cell_c_prev, fill(1));

    // Reset mid-EVAL aborts the step
    in_valid = 1'b1;
    x_in     = fill(9);
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_in_ready", 32'(in_ready), 32'd1);
    chk("s5_out_valid", 32'(out_valid), 32'd0);
    chk_vec("s5_h_reg", cell_h_prev, fill(0));
    chk("s5_step_cnt", 32'(step_cnt), 32'd0);
    tick();
    tick();
    chk("s5_no_output", 32'(out_valid), 32'd0);
    run_step(4, 1'b0, 1'b0, h, lst, sc);
    tick();
    chk_vec("s5_out_h", h, fill(4));

    // Single-step sequence
    run_step(-3, 1'b1, 1'b1, h, lst, sc);
    tick();
    chk_vec("s6_out_h", h, fill(-3));
    chk("s6_out_last", 32'(lst), 32'd1);
    chk("s6_step_cnt", 32'(sc), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lstm_step_seq.md
LSTM_STEP_SEQ -- requirements
Module: lstm_step_seq

Interface
REQ-001 SHALL have parameter VEC_LEN, default 100, elements per x/h/c vector.
REQ-002 SHALL have parameter DATA_W, default 32, signed element width.
REQ-003 SHALL have parameter SETTLE_CYC, default 2, clock cycles allowed for the combinational cell to settle (legal range 1..15).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge; all state changes on this edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  x_in, in_first and in_last valid.
REQ-007 SHALL have port in_ready  output  1  step accepted when in_valid && in_ready.
REQ-008 SHALL have port in_first  input  1  first timestep of a sequence; h and c are zeroed.
REQ-009 SHALL have port in_last  input  1  final timestep of a sequence.
REQ-010 SHALL have port x_in  input  VEC_LEN x DATA_W signed  input vector x_t.
REQ-011 SHALL have ports cell_x, cell_h_prev, cell_c_prev  output  VEC_LEN x DATA_W signed  registered operands to the external LSTM cell.
REQ-012 SHALL have ports cell_h_t, cell_c_next  input  VEC_LEN x DATA_W signed  cell results.
REQ-013 SHALL have port out_valid  output  1  out_h and out_last valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-015 SHALL have port out_h  output  VEC_LEN x DATA_W signed  registered h_t.
REQ-016 SHALL have port out_last  output  1  copy of the accepted in_last.
REQ-017 SHALL have port step_cnt  output  16  steps completed in the current sequence, saturating at 16'hFFFF.

Function
REQ-018 SHALL implement the FSM IDLE -> EVAL -> OUT -> IDLE; in_ready SHALL be 1 only in IDLE.
REQ-019 On accept in IDLE: x_reg <= x_in; last_reg <= in_last; if in_first, h_reg <= 0, c_reg <= 0 and step_cnt <= 0; state <= EVAL with settle counter = 0.
REQ-020 cell_x, cell_h_prev and cell_c_prev SHALL be driven directly from x_reg, h_reg and c_reg, and SHALL be stable throughout EVAL.
REQ-021 In EVAL the settle counter SHALL increment each cycle.
REQ-022 In the EVAL cycle where the counter equals SETTLE_CYC-1: h_reg <= cell_h_t, c_reg <= cell_c_next, out_h <= cell_h_t, out_last <= last_reg, step_cnt increments (saturating), state <= OUT.
REQ-023 out_valid SHALL equal (state == OUT); it is first high SETTLE_CYC+1 cycles after the accept edge.
REQ-024 In OUT, out_h and out_last SHALL hold until out_valid && out_ready; on that edge state <= IDLE; the next accept is possible one cycle later.
REQ-025 in_first and in_last together SHALL be legal (single-step sequence): zeroed state, one output with out_last = 1.
REQ-026 A step without in_first SHALL continue from the h_reg/c_reg captured by the previous step, including after a step with in_last.
REQ-027 No arithmetic SHALL be performed on data; values pass through bit-exact.

Reset
REQ-028 While rst is high at a clock edge: state <= IDLE; x_reg, h_reg, c_reg, out_h <= 0; out_last <= 0; step_cnt <= 0; settle counter <= 0.
REQ-029 After reset, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-030 Reset during EVAL or OUT SHALL abort the step with no output handshake.

Structure
REQ-031 Package lstm_pkg SHALL hold VEC_LEN/DATA_W defaults, the vector typedef and the FSM state enum.
REQ-032 The h/c storage (clear, load, hold) SHALL be one sub-module, lstm_state_bank; the LSTM cell stays outside this block.

Verification
REQ-033 Bench cell model: h_t[i] = x[i] + h_prev[i], c_next[i] = c_prev[i] + 1.
REQ-034 Scenario 1: three steps, x = all 5, first on step 1, out_ready = 1 -> out_h = 5, 10, 15; c_reg = 3; step_cnt = 3.
REQ-035 Scenario 2: SETTLE_CYC = 2, accept at cycle 0 -> out_valid rises at cycle 3; in_ready = 0 during cycles 1-3.
REQ-036 Scenario 3: out_ready held low for 10 cycles in OUT -> out_h is stable and in_ready = 0 throughout; data is accepted on release.
REQ-037 Scenario 4: after two steps, in_first with x = 7 -> out_h = 7 and step_cnt = 1.
REQ-038 Scenario 5: rst pulsed mid-EVAL -> next cycle state = IDLE, out_valid = 0, h_reg = 0; next step with x = 4 and no in_first -> out_h = 4.
REQ-039 Scenario 6: in_first = in_last = 1 with x = -3 -> out_h = -3 and out_last = 1.
